// File: rtl/fp_add_sequencer_if.sv
// rtl/fp_add_sequencer_if.sv - request, adder and result signal bundle for fp_add_sequencer
interface fp_add_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_rmode;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [2:0]       add_rmode;
    logic [31:0]      add_result;
    logic             add_overflow;
    logic             add_underflow;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_overflow;
    logic             out_underflow;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      op_count;

    modport slave (
        input  in_valid, in_a, in_b, in_rmode, in_sub, in_tag,
        output in_ready,
        output add_a, add_b, add_rmode,
        input  add_result, add_overflow, add_underflow,
        output out_valid, out_result, out_overflow, out_underflow, out_err, out_tag, op_count,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_rmode, in_sub, in_tag,
        input  in_ready,
        input  add_a, add_b, add_rmode,
        output add_result, add_overflow, add_underflow,
        input  out_valid, out_result, out_overflow, out_underflow, out_err, out_tag, op_count,
        output out_ready
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - queued issue stage for a combinational fp_adder
module fp_add_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_add_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [2:0]       rmode;
        logic             sub;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    op_t              mem_q [DEPTH];
    op_t              ex_q, ex_d;
    op_t              in_op;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]      res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [15:0]      cnt_q, cnt_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic rmode_bad;

    assign in_op = '{a: bus.in_a, b: bus.in_b, rmode: bus.in_rmode,
                     sub: bus.in_sub, tag: bus.in_tag};

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state_q == IDLE) && !empty;
    assign rmode_bad    = (ex_q.rmode > 3'd4);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_comb begin
        state_d       = state_q;
        ex_d          = ex_q;
        res_d         = res_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        err_d         = err_q;
        tag_d         = tag_q;
        cnt_d         = cnt_q;
        bus.add_a     = 32'd0;
        bus.add_b     = 32'd0;
        bus.add_rmode = 3'd0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    ex_d    = mem_q[rd_ptr_q[AW-1:0]];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                bus.add_a     = ex_q.a;
                bus.add_b     = ex_q.sub ? {~ex_q.b[31], ex_q.b[30:0]} : ex_q.b;
                bus.add_rmode = rmode_bad ? 3'd0 : ex_q.rmode;
                // Illegal rounding modes answer with a canonical qNaN; adder output is discarded.
                if (rmode_bad) begin
                    res_d = 32'h7fc0_0000;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    res_d = bus.add_result;
                    ovf_d = bus.add_overflow;
                    unf_d = bus.add_underflow;
                    err_d = 1'b0;
                end
                tag_d   = ex_q.tag;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ex_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            res_q    <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
            tag_q    <= '0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_op;
        end
    end

    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_result    = res_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_err       = err_q;
    assign bus.out_tag       = tag_q;
    assign bus.op_count      = cnt_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - self-checking bench for fp_add_sequencer
module tb_fp_add_sequencer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_sequencer_if #(.TAG_W(TAG_W)) bus ();

    fp_add_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] add_b;
        logic [2:0]  add_rm;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    logic rnd_on = 1'b0;

    // Stand-in for the combinational fp_adder: exact answers for the IEEE cases, a cheap hash otherwise.
    function automatic logic [33:0] adder_stub(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] rm);
        if (a == 32'h3f800000 && b == 32'h3f800000) return {2'b00, 32'h40000000};
        if (a == 32'h3f800000 && b == 32'hbf800000) return {2'b00, 32'h00000000};
        if (a == 32'h7f800000 && b == 32'hff800000) return {2'b00, 32'h7fc00000};
        return {a[0] ^ b[0], a[1] & b[1], (a + b) ^ {29'd0, rm}};
    endfunction

    always_comb begin
        {bus.add_overflow, bus.add_underflow, bus.add_result} =
            adder_stub(bus.add_a, bus.add_b, bus.add_rmode);
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] rm, input logic sub, input logic [3:0] tag);
        exp_t        e;
        logic [33:0] r;
        logic [31:0] bb;
        e.tag = tag;
        if (rm >= 3'd5) begin
            e.res = 32'h7fc00000;
            e.ovf = 1'b0;
            e.unf = 1'b0;
            e.err = 1'b1;
        end else begin
            bb    = sub ? (b ^ 32'h80000000) : b;
            r     = adder_stub(a, bb, rm);
            e.res = r[31:0];
            e.ovf = r[33];
            e.unf = r[32];
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_result", bus.out_result, mon_e.res);
                chk("mon_tag", 32'(bus.out_tag), 32'(mon_e.tag));
                chk("mon_err", 32'(bus.out_err), 32'(mon_e.err));
                chk("mon_ovf", 32'(bus.out_overflow), 32'(mon_e.ovf));
                chk("mon_unf", 32'(bus.out_underflow), 32'(mon_e.unf));
                chk("mon_op_count", 32'(bus.op_count), 32'(n_done[15:0]));
            end
            n_done++;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic sub, input logic [3:0] tag);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rmode = rm;
        bus.in_sub   = sub;
        bus.in_tag   = tag;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) chk("push_timeout", 32'd0, 32'd1);
        else exp_q.push_back(model(a, b, rm, sub, tag));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
    endtask

    task automatic drain(input string name);
        int w = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk({name, "_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_op_count"}, 32'(bus.op_count), 32'(n_done[15:0]));
        bus.out_ready = 1'b0;
    endtask

    task automatic run_single(input vec_t v);
        push(v.a, v.b, v.rm, v.sub, v.tag);
        @(negedge clk);
        chk("c1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("c1_add_a", bus.add_a, 32'd0);
        @(negedge clk);
        chk("c2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("c2_add_a", bus.add_a, v.a);
        chk("c2_add_b", bus.add_b, v.add_b);
        chk("c2_add_rmode", 32'(bus.add_rmode), 32'(v.add_rm));
        @(negedge clk);
        chk("c3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("c3_result", bus.out_result, v.res);
        chk("c3_ovf", 32'(bus.out_overflow), 32'(v.ovf));
        chk("c3_unf", 32'(bus.out_underflow), 32'(v.unf));
        chk("c3_err", 32'(bus.out_err), 32'(v.err));
        chk("c3_tag", 32'(bus.out_tag), 32'(v.tag));
        chk("c3_add_a_idle", bus.add_a, 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        vecs[0] = '{32'h3f800000, 32'h3f800000, 3'd0, 1'b0, 4'd3,
                    32'h3f800000, 3'd0, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h3f800000, 32'h3f800000, 3'd1, 1'b1, 4'd5,
                    32'hbf800000, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h40000000, 32'h3f800000, 3'd6, 1'b0, 4'd7,
                    32'h3f800000, 3'd0, 32'h7fc00000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h7f800000, 32'h7f800000, 3'd0, 1'b1, 4'd9,
                    32'hff800000, 3'd0, 32'h7fc00000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h00000003, 32'h00000002, 3'd2, 1'b0, 4'd15,
                    32'h00000002, 3'd2, 32'h00000007, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h1234567b, 32'h80000002, 3'd7, 1'b1, 4'd10,
                    32'h00000002, 3'd0, 32'h7fc00000, 1'b0, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_rmode  = 3'd0;
        bus.in_sub    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_add_b", bus.add_b, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_single(vecs[i]);
        chk("table_op_count", 32'(bus.op_count), 32'd6);

        // Backpressure: DEPTH+1 ops with the consumer stalled.
        base = n_done;
        for (int t = 0; t <= DEPTH; t++) begin
            push($urandom, $urandom, 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 4'(t));
        end
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_out_tag", 32'(bus.out_tag), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_out_tag", 32'(bus.out_tag), 32'd0);
        chk("hold_out_result", bus.out_result, exp_q[0].res);
        chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain("bp");
        chk("bp_completed", 32'(n_done - base), 32'(DEPTH + 1));

        // Randomized traffic with random consumer stalls.
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    push($urandom, $urandom, 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 4'($urandom));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("rnd");

        // Reset with work in flight and queued.
        bus.out_ready = 1'b0;
        push(32'h00000010, 32'h00000020, 3'd0, 1'b0, 4'd1);
        push(32'h00000030, 32'h00000040, 3'd1, 1'b0, 4'd2);
        push(32'h00000050, 32'h00000060, 3'd2, 1'b1, 4'd3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_comb", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_op_count", 32'(bus.op_count), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_add_a", bus.add_a, 32'd0);
        exp_q.delete();
        n_done = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("relrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("relrst_no_exec", bus.add_a | 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        run_single(vecs[0]);
        @(negedge clk);
        chk("relrst_op_count", 32'(bus.op_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
